// File: rtl/render_frame_ctrl.sv
// Frame sequencer for a pixel renderer: staged config registers, IDLE/LOAD/RUN control and frame counting.
// Optional AUTO_PAN_EN adds XSTEP/YSTEP registers that advance the staged offsets on every LOAD.
module render_frame_ctrl #(
    parameter int unsigned FRAME_CNT_W  = 16,
    parameter int unsigned ITER_DEFAULT = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   pix_valid,
    input  logic                   pix_ready,
    input  logic                   pix_last_x,
    input  logic                   pix_last_y,
    output logic                   gen_reset,
    output logic [5:0]             iterations_max,
    output logic [2:0]             zoom,
    output logic [24:0]            x_offset,
    output logic [24:0]            y_offset,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned ITER_W = 6;
    localparam int unsigned ZOOM_W = 3;
    localparam int unsigned OFF_W  = 25;

    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_ITER = 3'd1;
    localparam logic [2:0] ADDR_ZOOM = 3'd2;
    localparam logic [2:0] ADDR_XOFF = 3'd3;
    localparam logic [2:0] ADDR_YOFF = 3'd4;
`ifdef AUTO_PAN_EN
    localparam logic [2:0] ADDR_XSTEP = 3'd5;
    localparam logic [2:0] ADDR_YSTEP = 3'd6;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t              state;
    logic                stg_run;
    logic                stg_oneshot;
    logic [ITER_W-1:0]   stg_iter;
    logic [ZOOM_W-1:0]   stg_zoom;
    logic [OFF_W-1:0]    stg_xoff;
    logic [OFF_W-1:0]    stg_yoff;
`ifdef AUTO_PAN_EN
    logic [OFF_W-1:0]    stg_xstep;
    logic [OFF_W-1:0]    stg_ystep;
`endif

    logic eof_c;
    logic unused_wdata_c;

    assign eof_c          = pix_valid & pix_ready & pix_last_x & pix_last_y & (state == RUN);
    assign unused_wdata_c = ^cfg_wdata[31:25];

    // Sequencer, shadow registers and staging; a cfg write is applied last so it wins over internal updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            gen_reset      <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            iterations_max <= ITER_W'(ITER_DEFAULT);
            zoom           <= '0;
            x_offset       <= '0;
            y_offset       <= '0;
            stg_run        <= 1'b0;
            stg_oneshot    <= 1'b0;
            stg_iter       <= ITER_W'(ITER_DEFAULT);
            stg_zoom       <= '0;
            stg_xoff       <= '0;
            stg_yoff       <= '0;
`ifdef AUTO_PAN_EN
            stg_xstep      <= '0;
            stg_ystep      <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    gen_reset <= 1'b1;
                    busy      <= stg_run;
                    if (stg_run) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    iterations_max <= stg_iter;
                    zoom           <= stg_zoom;
                    x_offset       <= stg_xoff;
                    y_offset       <= stg_yoff;
`ifdef AUTO_PAN_EN
                    stg_xoff       <= stg_xoff + stg_xstep;
                    stg_yoff       <= stg_yoff + stg_ystep;
`endif
                    gen_reset      <= 1'b0;
                    busy           <= 1'b1;
                    state          <= RUN;
                end
                RUN: begin
                    if (eof_c) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + FRAME_CNT_W'(1);
                        gen_reset   <= 1'b1;
                        if (stg_oneshot) begin
                            stg_run <= 1'b0;
                        end
                        if (stg_run && !stg_oneshot) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gen_reset <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase

            if (cfg_wr) begin
                case (cfg_addr)
                    ADDR_CTRL: begin
                        stg_run     <= cfg_wdata[0];
                        stg_oneshot <= cfg_wdata[1];
                    end
                    ADDR_ITER: stg_iter <= (cfg_wdata[ITER_W-1:0] == '0) ? ITER_W'(1)
                                                                          : cfg_wdata[ITER_W-1:0];
                    ADDR_ZOOM: stg_zoom <= cfg_wdata[ZOOM_W-1:0];
                    ADDR_XOFF: stg_xoff <= cfg_wdata[OFF_W-1:0];
                    ADDR_YOFF: stg_yoff <= cfg_wdata[OFF_W-1:0];
`ifdef AUTO_PAN_EN
                    ADDR_XSTEP: stg_xstep <= cfg_wdata[OFF_W-1:0];
                    ADDR_YSTEP: stg_ystep <= cfg_wdata[OFF_W-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_render_frame_ctrl.sv
// Directed bench for render_frame_ctrl; DUT built with a 4-bit frame counter so the wrap is reachable.
module tb_render_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        pix_valid, pix_ready, pix_last_x, pix_last_y;
    logic        gen_reset;
    logic [5:0]  iterations_max;
    logic [2:0]  zoom;
    logic [24:0] x_offset, y_offset;
    logic        busy, frame_done;
    logic [3:0]  frame_count;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    render_frame_ctrl #(.FRAME_CNT_W(4), .ITER_DEFAULT(50)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last_x(pix_last_x), .pix_last_y(pix_last_y),
        .gen_reset(gen_reset), .iterations_max(iterations_max), .zoom(zoom),
        .x_offset(x_offset), .y_offset(y_offset), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic set_pix(input logic [3:0] p);
        {pix_valid, pix_ready, pix_last_x, pix_last_y} = p;
    endtask

    // Streams a w x h frame; lines from 2 on only present their last pixel to keep long frames short.
    task automatic stream_frame(input int w, input int h, input int wr_at, input logic [2:0] wa,
                                input logic [31:0] wd, output int pulses, output int pulse_idx,
                                output int idle_seen);
        pulses = 0; pulse_idx = -1; idle_seen = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y >= 2 && x != w - 1) continue;
                set_pix({1'b1, 1'b1, (x == w - 1), (y == h - 1)});
                if (y * w + x == wr_at) begin
                    cfg_wr = 1'b1; cfg_addr = wa; cfg_wdata = wd;
                end
                tick();
                cfg_wr = 1'b0;
                if (frame_done) begin
                    pulses++;
                    pulse_idx = y * w + x;
                end
                if (!busy && (y * w + x) < w * h - 1) idle_seen++;
            end
        end
        set_pix(4'b0000);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (gen_reset !== 1'b1) begin failures++; $display("FAIL rst_gen_reset: got %b want 1", gen_reset); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        checks++; if (frame_count !== 4'd0) begin failures++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
        checks++; if (iterations_max !== 6'd50) begin failures++; $display("FAIL rst_iter: got %0d want 50", iterations_max); end
        checks++; if (zoom !== 3'd0) begin failures++; $display("FAIL rst_zoom: got %0d want 0", zoom); end
        checks++; if (x_offset !== 25'd0 || y_offset !== 25'd0) begin failures++; $display("FAIL rst_offsets: got %h/%h want 0/0", x_offset, y_offset); end
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || gen_reset !== 1'b1) begin failures++; $display("FAIL rst_stay_idle: got busy=%b gen_reset=%b want 0/1", busy, gen_reset); end
    endtask

    task automatic test_start_iter0();
        cfg_write(3'd1, 32'd0);
        cfg_write(3'd0, 32'd1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_idle: got busy=%b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b1 || gen_reset !== 1'b1) begin failures++; $display("FAIL start_load: got busy=%b gen_reset=%b want 1/1", busy, gen_reset); end
        checks++; if (iterations_max !== 6'd50) begin failures++; $display("FAIL start_iter_in_load: got %0d want 50", iterations_max); end
        tick();
        checks++; if (gen_reset !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_run: got busy=%b gen_reset=%b want 1/0", busy, gen_reset); end
        checks++; if (iterations_max !== 6'd1) begin failures++; $display("FAIL start_iter0: got %0d want 1", iterations_max); end
    endtask

    task automatic test_zoom_midframe();
        int p, li, idl;
        stream_frame(8, 4, 5, 3'd2, 32'd2, p, li, idl);
        exp_count++;
        checks++; if (p !== 1 || li !== 31) begin failures++; $display("FAIL zoom_pulse: got pulses=%0d at=%0d want 1 at 31", p, li); end
        checks++; if (zoom !== 3'd0) begin failures++; $display("FAIL zoom_held: got %0d want 0", zoom); end
        checks++; if (frame_count !== 4'(exp_count)) begin failures++; $display("FAIL zoom_count: got %0d want %0d", frame_count, exp_count); end
        checks++; if (busy !== 1'b1 || gen_reset !== 1'b1) begin failures++; $display("FAIL zoom_reload: got busy=%b gen_reset=%b want 1/1", busy, gen_reset); end
        tick();
        checks++; if (zoom !== 3'd2 || gen_reset !== 1'b0) begin failures++; $display("FAIL zoom_applied: got zoom=%0d gen_reset=%b want 2/0", zoom, gen_reset); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL zoom_pulse_width: got %b want 0", frame_done); end
    endtask

    task automatic test_eof_qualify();
        logic [3:0] pats [4];
        int seen = 0;
        pats = '{4'b1011, 4'b1110, 4'b0111, 4'b1101};
        for (int i = 0; i < 4; i++) begin
            set_pix(pats[i]);
            tick();
            if (frame_done) seen++;
        end
        set_pix(4'b0000);
        checks++; if (seen !== 0) begin failures++; $display("FAIL eof_qualify: got %0d pulses want 0", seen); end
        checks++; if (frame_count !== 4'(exp_count) || busy !== 1'b1) begin failures++; $display("FAIL eof_qualify_state: got count=%0d busy=%b want %0d/1", frame_count, busy, exp_count); end
    endtask

    task automatic test_oneshot();
        int p, li, idl, stray;
        cfg_write(3'd0, 32'd3);
        stream_frame(8, 4, -1, 3'd0, 32'd0, p, li, idl);
        exp_count++;
        checks++; if (p !== 1 || li !== 31) begin failures++; $display("FAIL oneshot_pulse: got pulses=%0d at=%0d want 1 at 31", p, li); end
        checks++; if (busy !== 1'b0 || gen_reset !== 1'b1) begin failures++; $display("FAIL oneshot_idle: got busy=%b gen_reset=%b want 0/1", busy, gen_reset); end
        checks++; if (frame_count !== 4'(exp_count)) begin failures++; $display("FAIL oneshot_count: got %0d want %0d", frame_count, exp_count); end
        stray = 0;
        set_pix(4'b1111);
        repeat (4) begin
            tick();
            if (busy || frame_done) stray++;
        end
        set_pix(4'b0000);
        checks++; if (stray !== 0) begin failures++; $display("FAIL oneshot_run_cleared: got %0d busy/done cycles want 0", stray); end
        checks++; if (frame_count !== 4'(exp_count)) begin failures++; $display("FAIL idle_ignores_pix: got %0d want %0d", frame_count, exp_count); end
    endtask

    task automatic test_clear_midframe();
        int p, li, idl;
        cfg_write(3'd0, 32'd1);
        tick(); tick();
        checks++; if (gen_reset !== 1'b0) begin failures++; $display("FAIL clear_start: got gen_reset=%b want 0", gen_reset); end
        stream_frame(640, 480, 1000, 3'd0, 32'd0, p, li, idl);
        exp_count++;
        checks++; if (p !== 1 || li !== 307199) begin failures++; $display("FAIL clear_pulse: got pulses=%0d at=%0d want 1 at 307199", p, li); end
        checks++; if (idl !== 0) begin failures++; $display("FAIL clear_no_truncate: got %0d idle samples want 0", idl); end
        tick();
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL clear_idle: got busy=%b done=%b want 0/0", busy, frame_done); end
        checks++; if (frame_count !== 4'(exp_count)) begin failures++; $display("FAIL clear_count: got %0d want %0d", frame_count, exp_count); end
    endtask

    task automatic test_load_collision();
        int p, li, idl;
        cfg_write(3'd0, 32'd1);
        tick();
        checks++; if (busy !== 1'b1 || gen_reset !== 1'b1) begin failures++; $display("FAIL coll_in_load: got busy=%b gen_reset=%b want 1/1", busy, gen_reset); end
        cfg_write(3'd2, 32'd5);
        checks++; if (zoom !== 3'd2 || gen_reset !== 1'b0) begin failures++; $display("FAIL coll_pre_write: got zoom=%0d gen_reset=%b want 2/0", zoom, gen_reset); end
        stream_frame(4, 2, -1, 3'd0, 32'd0, p, li, idl);
        exp_count++;
        tick();
        checks++; if (zoom !== 3'd5) begin failures++; $display("FAIL coll_next_load: got zoom=%0d want 5", zoom); end
        checks++; if (frame_count !== 4'(exp_count)) begin failures++; $display("FAIL coll_count: got %0d want %0d", frame_count, exp_count); end
    endtask

    task automatic test_count_wrap();
        int p, li, idl;
        for (int i = 0; i < 16; i++) begin
            stream_frame(4, 2, -1, 3'd0, 32'd0, p, li, idl);
            exp_count = (exp_count + 1) % 16;
            checks++; if (frame_count !== 4'(exp_count) || p !== 1) begin failures++; $display("FAIL wrap_frame%0d: got count=%0d pulses=%0d want %0d/1", i, frame_count, p, exp_count); end
        end
        tick();
    endtask

    task automatic test_auto_pan();
        int p, li, idl;
        logic [24:0] exp_x [3];
`ifdef AUTO_PAN_EN
        exp_x = '{25'h0000000, 25'h1FFFFFF, 25'h1FFFFFE};
`else
        exp_x = '{25'h0000000, 25'h0000000, 25'h0000000};
`endif
        cfg_write(3'd3, 32'd0);
        cfg_write(3'd5, 32'h01FF_FFFF);
        cfg_write(3'd6, 32'd0);
        cfg_write(3'd4, 32'hABCD_EF01);
        cfg_write(3'd1, 32'hFFFF_FFC5);
        cfg_write(3'd7, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            stream_frame(4, 2, -1, 3'd0, 32'd0, p, li, idl);
            exp_count = (exp_count + 1) % 16;
            tick();
            checks++; if (x_offset !== exp_x[k]) begin failures++; $display("FAIL pan_x%0d: got %h want %h", k, x_offset, exp_x[k]); end
            checks++; if (y_offset !== 25'h1CDEF01 || iterations_max !== 6'd5) begin failures++; $display("FAIL pan_cfg%0d: got y=%h iter=%0d want 1cdef01/5", k, y_offset, iterations_max); end
            checks++; if (busy !== 1'b1 || frame_count !== 4'(exp_count)) begin failures++; $display("FAIL pan_run%0d: got busy=%b count=%0d want 1/%0d", k, busy, frame_count, exp_count); end
        end
        stream_frame(4, 2, 2, 3'd0, 32'd0, p, li, idl);
        checks++; if (busy !== 1'b0 || p !== 1) begin failures++; $display("FAIL pan_stop: got busy=%b pulses=%0d want 0/1", busy, p); end
    endtask

    task automatic test_reset_mid_frame();
        cfg_write(3'd0, 32'd1);
        tick(); tick();
        set_pix(4'b1110);
        tick();
        set_pix(4'b1100);
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || gen_reset !== 1'b1) begin failures++; $display("FAIL async_rst: got busy=%b gen_reset=%b want 0/1", busy, gen_reset); end
        checks++; if (frame_count !== 4'd0 || iterations_max !== 6'd50 || y_offset !== 25'd0) begin failures++; $display("FAIL async_rst_regs: got count=%0d iter=%0d y=%h want 0/50/0", frame_count, iterations_max, y_offset); end
        tick();
        reset = 1'b0;
        set_pix(4'b1111);
        repeat (4) tick();
        set_pix(4'b0000);
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== 4'd0) begin failures++; $display("FAIL rst_discard: got busy=%b done=%b count=%0d want 0/0/0", busy, frame_done, frame_count); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cfg_wr = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
        set_pix(4'b0000);
        #1;
        test_reset();
        test_start_iter0();
        test_zoom_midframe();
        test_eof_qualify();
        test_oneshot();
        test_clear_midframe();
        test_load_collision();
        test_count_wrap();
        test_auto_pan();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
